// File: rtl/can_tx_frame_serializer_if.sv
// Bundle for the CAN TX serializer: frame request, CRC engine link and serial output.
// The master side submits frames and supplies the CRC; the slave side is the serializer.
interface can_tx_frame_serializer_if;
    // Frame request. start is a request that the serializer takes only while busy=0.
    // id/rtr/dlc/data are captured on that same edge.
    logic        start;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        busy;
    logic        done;

    // CRC-15 engine link
    logic [14:0] crc;
    logic        crc_din;
    logic        crc_en;

    // Serial stream to the bit stuffer (no backpressure)
    logic        bit_out;
    logic        bit_valid;
    logic [2:0]  field;

    modport master (
        output start, id, rtr, dlc, data, crc,
        input  busy, done, crc_din, crc_en, bit_out, bit_valid, field
    );

    modport slave (
        input  start, id, rtr, dlc, data, crc,
        output busy, done, crc_din, crc_en, bit_out, bit_valid, field
    );
endinterface

// File: rtl/can_tx_frame_serializer.sv
// Serializes one CAN 2.0A standard data/remote frame, one unstuffed bit per clock,
// driving the CRC-15 engine over the covered bits and appending CRC and delimiter.
module can_tx_frame_serializer #(
    parameter int unsigned DLC_MAX = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    can_tx_frame_serializer_if.slave      bus
);

    // State encoding doubles as the field code, so field is the FSM state itself.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_CTRL  = 3'd2,
        S_DATA  = 3'd3,
        S_CAP   = 3'd4,
        S_CRC   = 3'd5,
        S_DELIM = 3'd6
    } state_t;

    localparam logic [3:0] DLC_CAP   = (DLC_MAX > 8) ? 4'd8 : 4'(DLC_MAX);
    localparam logic [6:0] ARB_LAST  = 7'd12;
    localparam logic [6:0] CTRL_LAST = 7'd18;
    localparam logic [3:0] CRC_LAST  = 4'd14;

    state_t      state_q;
    state_t      state_d;
    logic [6:0]  cnt_q;
    logic [6:0]  cnt_d;
    logic [3:0]  crc_cnt_q;
    logic [3:0]  crc_cnt_d;
    logic        done_q;
    logic        done_d;

    // Covered bits held MSB-first: SOF, id, rtr, IDE, r0, dlc, data.
    logic [82:0] frame_q;
    logic [6:0]  last_q;
    logic [14:0] crc_sr_q;

    logic [3:0]  n_bytes;
    logic [6:0]  last_d;
    logic        accept;
    logic        cov_bit;

    assign accept = (state_q == S_IDLE) && bus.start;

    always_comb begin
        n_bytes = 4'd0;
        if (!bus.rtr) begin
            n_bytes = (bus.dlc > DLC_CAP) ? DLC_CAP : bus.dlc;
        end
        last_d = CTRL_LAST + {n_bytes, 3'b000};
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 7'd0;
            crc_cnt_q <= 4'd0;
            done_q    <= 1'b0;
            frame_q   <= '0;
            last_q    <= 7'd0;
            crc_sr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_cnt_q <= crc_cnt_d;
            done_q    <= done_d;
            if (accept) begin
                frame_q <= {1'b0, bus.id, bus.rtr, 2'b00, bus.dlc, bus.data};
                last_q  <= last_d;
            end
            // The engine still holds the final CRC during the capture cycle.
            if (state_q == S_CAP) begin
                crc_sr_q <= bus.crc;
            end else if (state_q == S_CRC) begin
                crc_sr_q <= {crc_sr_q[13:0], 1'b0};
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_cnt_d = crc_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ARB;
                    cnt_d   = 7'd0;
                end
            end
            S_ARB: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == ARB_LAST) state_d = S_CTRL;
            end
            S_CTRL: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == CTRL_LAST) begin
                    state_d = (last_q == CTRL_LAST) ? S_CAP : S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == last_q) state_d = S_CAP;
            end
            S_CAP: begin
                state_d   = S_CRC;
                crc_cnt_d = 4'd0;
            end
            S_CRC: begin
                crc_cnt_d = crc_cnt_q + 4'd1;
                if (crc_cnt_q == CRC_LAST) state_d = S_DELIM;
            end
            S_DELIM: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cov_bit = 1'b1;
        if (cnt_q <= 7'd82) begin
            cov_bit = frame_q[7'd82 - cnt_q];
        end
    end

    // Output logic; crc_en must not drop between covered bits or the engine reseeds.
    always_comb begin
        bus.bit_out   = 1'b1;
        bus.bit_valid = 1'b0;
        bus.crc_en    = 1'b0;
        bus.crc_din   = 1'b0;
        bus.field     = state_q;
        bus.busy      = (state_q != S_IDLE);
        bus.done      = done_q;
        case (state_q)
            S_ARB, S_CTRL, S_DATA: begin
                bus.bit_out   = cov_bit;
                bus.bit_valid = 1'b1;
                bus.crc_en    = 1'b1;
                bus.crc_din   = cov_bit;
            end
            S_CRC: begin
                bus.bit_out   = crc_sr_q[14];
                bus.bit_valid = 1'b1;
            end
            S_DELIM: begin
                bus.bit_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_can_tx_frame_serializer.sv
// Bench for can_tx_frame_serializer: table-driven frames with a stubbed CRC,
// chained/held start, mid-frame reset, and random frames against a CRC-15 model.
module tb_can_tx_frame_serializer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    can_tx_frame_serializer_if bus();

    can_tx_frame_serializer #(.DLC_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // CRC engine stand-in: stubbed constant, or an LFSR that reseeds to all ones while disabled.
    logic        use_stub;
    logic [14:0] stub_crc;
    logic [14:0] eng;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic [14:0] n;
        n = {c[13:0], 1'b0};
        if (b ^ c[14]) n = n ^ 15'h4599;
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (!bus.crc_en) eng <= 15'h7FFF;
        else             eng <= crc_step(eng, bus.crc_din);
    end

    assign bus.crc = use_stub ? stub_crc : eng;

    typedef struct {
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic [14:0] crc;
        logic [82:0] exp_cov;
        int          n_cov;
    } vec_t;

    vec_t vt[6];

    function automatic logic [8:0] pk(input logic b, input logic v, input logic en,
                                      input logic din, input logic [2:0] f,
                                      input logic busy, input logic done);
        return {b, v, en, din, f, busy, done};
    endfunction

    function automatic logic [8:0] obs();
        return pk(bus.bit_out, bus.bit_valid, bus.crc_en, bus.crc_din, bus.field, bus.busy, bus.done);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_start(input int idx);
        bus.id    = vt[idx].id;
        bus.rtr   = vt[idx].rtr;
        bus.dlc   = vt[idx].dlc;
        bus.data  = vt[idx].data;
        stub_crc  = vt[idx].crc;
        bus.start = 1'b1;
    endtask

    task automatic scramble();
        bus.id   = 11'($urandom);
        bus.rtr  = 1'($urandom);
        bus.dlc  = 4'($urandom);
        bus.data = {$urandom, $urandom};
    endtask

    // Checks every cycle from SOF to the done pulse; start was driven at the current negedge.
    task automatic run_frame(input int idx, input bit hold, input bit chain, input int nidx);
        int n;
        int j;
        logic b;
        logic [8:0] e;
        logic [2:0] f;
        n = vt[idx].n_cov;
        for (int k = 1; k <= n + 18; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (!hold) bus.start = 1'b0;
                scramble();
            end
            if (hold && k == n + 17) bus.start = 1'b0;
            if (k <= n) begin
                b = vt[idx].exp_cov[83 - k];
                f = (k <= 13) ? 3'd1 : (k <= 19) ? 3'd2 : 3'd3;
                e = pk(b, 1'b1, 1'b1, b, f, 1'b1, 1'b0);
            end else if (k == n + 1) begin
                e = pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
            end else if (k <= n + 16) begin
                j = k - n - 2;
                b = vt[idx].crc[14 - j];
                e = pk(b, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0);
            end else if (k == n + 17) begin
                e = pk(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0);
            end else begin
                e = pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
            end
            check($sformatf("frame%0d_cyc%0d", idx, k), 32'(obs()), 32'(e));
            if (k == n + 18 && chain) drive_start(nidx);
        end
        if (!chain) begin
            @(negedge clk);
            check($sformatf("frame%0d_idle", idx), 32'(obs()),
                  32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0)));
        end
    endtask

    function automatic logic [14:0] ref_crc(input logic [10:0] id, input logic rtr,
                                            input logic [3:0] dlc, input logic [63:0] data);
        logic [82:0] v;
        logic [14:0] c;
        int nb;
        v  = {1'b0, id, rtr, 2'b00, dlc, data};
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        c  = 15'h7FFF;
        for (int i = 0; i < 19 + 8 * nb; i++) c = crc_step(c, v[82 - i]);
        return c;
    endfunction

    logic [10:0] r_id;
    logic        r_rtr;
    logic [3:0]  r_dlc;
    logic [63:0] r_data;
    logic [14:0] got;
    int          nv;
    int          nb;
    bit          seen;

    initial begin
        vt[0] = '{11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 15'h4A5C,
                  {27'b0_00100100011_0_0_0_0001_10100101, 56'd0}, 27};
        vt[1] = '{11'h5A3, 1'b1, 4'd4, 64'hDEAD_BEEF_0000_1111, 15'h1234,
                  {19'b0_10110100011_1_0_0_0100, 64'd0}, 19};
        vt[2] = '{11'h00F, 1'b0, 4'hC, 64'h0123_4567_89AB_CDEF, 15'h2C3A,
                  {19'b0_00000001111_0_0_0_1100, 64'h0123_4567_89AB_CDEF}, 83};
        vt[3] = '{11'h400, 1'b0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 15'h0001,
                  {19'b0_10000000000_0_0_0_0000, 64'd0}, 19};
        vt[4] = '{11'h2AA, 1'b0, 4'd8, 64'hFEDC_BA98_7654_3210, 15'h7FFF,
                  {19'b0_01010101010_0_0_0_1000, 64'hFEDC_BA98_7654_3210}, 83};
        vt[5] = '{11'h001, 1'b1, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 15'h5555,
                  {19'b0_00000000001_1_0_0_1111, 64'd0}, 19};

        use_stub  = 1'b1;
        stub_crc  = 15'h0000;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.id    = 11'h7FF;
        bus.rtr   = 1'b0;
        bus.dlc   = 4'd0;
        bus.data  = '0;

        // Reset values, then idle after release with start low
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(obs()), 32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0)));
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle%0d", i), 32'(obs()),
                  32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0)));
        end

        drive_start(0); run_frame(0, 1'b0, 1'b0, 0);
        drive_start(1); run_frame(1, 1'b0, 1'b0, 0);
        drive_start(2); run_frame(2, 1'b1, 1'b0, 0);
        drive_start(3); run_frame(3, 1'b0, 1'b1, 4);
        run_frame(4, 1'b0, 1'b0, 0);
        drive_start(5); run_frame(5, 1'b1, 1'b1, 0);
        run_frame(0, 1'b0, 1'b0, 0);

        // Reset in the middle of the data field of a DLC=8 frame
        drive_start(4);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        check("midreset_in_data", 32'(bus.field), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_outputs", 32'(obs()), 32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0)));
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midreset_no_done%0d", i), 32'(obs()),
                  32'(pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0)));
        end
        drive_start(0); run_frame(0, 1'b0, 1'b0, 0);

        // Random frames with the LFSR engine in the loop
        use_stub = 1'b0;
        for (int fr = 0; fr < 200; fr++) begin
            r_id   = 11'($urandom);
            r_rtr  = ($urandom_range(0, 3) == 0);
            r_dlc  = 4'($urandom_range(0, 15));
            r_data = {$urandom, $urandom};
            nb     = r_rtr ? 0 : ((r_dlc > 4'd8) ? 8 : int'(r_dlc));
            bus.id = r_id; bus.rtr = r_rtr; bus.dlc = r_dlc; bus.data = r_data;
            bus.start = 1'b1;
            got  = '0;
            nv   = 0;
            seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge clk);
                if (c == 0) bus.start = 1'b0;
                if (bus.bit_valid) nv++;
                if (bus.field == 3'd5) got = {got[13:0], bus.bit_out};
                if (bus.done) seen = 1'b1;
            end
            check($sformatf("rand%0d_done", fr), 32'(seen), 32'd1);
            check($sformatf("rand%0d_crc", fr), 32'(got), 32'(ref_crc(r_id, r_rtr, r_dlc, r_data)));
            check($sformatf("rand%0d_bits", fr), 32'(nv), 32'(35 + 8 * nb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
